// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard controller. Converts taken branches into per-stage bubble
//   windows that travel down the pipe, freezes the pipe on stall requests,
//   merges branches that arrive during a stall into one deferred flush, and
//   flags stall episodes that last too long.
//
// Ports
//   clk_i        single clock, rising edge
//   resetn_i     asynchronous active-low reset
//   branch_en_i  taken branch / redirect, one flush per high cycle
//   stall_req_i  per-stage stall request, bit s = stage s
//   halt_o       per-stage bubble insert
//   stall_o      per-stage hold (all stages up to the highest requester)
//   pc_hold_o    fetch / PC hold
//   busy_o       flush pending or flush token still travelling
//   timeout_o    one-cycle pulse when a stall reaches STALL_MAX cycles
module pipe_hazard_ctrl #(
    parameter int STAGES    = 4,
    parameter int BUBBLE    = 2,
    parameter int STALL_MAX = 15
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              branch_en_i,
    input  logic [STAGES-1:0] stall_req_i,
    output logic [STAGES-1:0] halt_o,
    output logic [STAGES-1:0] stall_o,
    output logic              pc_hold_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int CW = $clog2(STALL_MAX + 1);

    logic              stall_any;
    logic              flush_e;
    logic              pend_q;
    logic [STAGES-1:1] tok_q;
    logic [STAGES-1:0] tok_all;
    logic [STAGES-1:0] halt_c;
    logic [STAGES-1:0] stall_c;
    logic [CW-1:0]     cnt_q;
    logic              timeout_c;

    assign stall_any = |stall_req_i;
    // A branch seen during a stall is deferred; it fires on the first free cycle.
    assign flush_e   = (branch_en_i | pend_q) & ~stall_any;
    // Position 0 is the flush happening this cycle, so stage 0 halts at once.
    assign tok_all   = {tok_q, flush_e};

    // A stalled stage also holds every stage upstream of it.
    always_comb begin
        stall_c = '0;
        for (int j = 0; j < STAGES; j++) begin
            stall_c[j] = |(stall_req_i >> j);
        end
    end

    // Stage k is halted while any token sits within the last BUBBLE positions
    // ending at k; overlapping flushes therefore simply OR together.
    always_comb begin
        halt_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            for (int d = 0; d < STAGES; d++) begin
                if ((d <= k) && (d + BUBBLE > k)) begin
                    halt_c[k] = halt_c[k] | tok_all[d];
                end
            end
        end
    end

    assign timeout_c = stall_any && (cnt_q == CW'(STALL_MAX - 1));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            tok_q  <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (!stall_any) begin
                tok_q <= tok_all[STAGES-2:0];
            end

            if (branch_en_i && stall_any) begin
                pend_q <= 1'b1;
            end else if (flush_e) begin
                pend_q <= 1'b0;
            end

            if (!stall_any) begin
                cnt_q <= '0;
            end else if (cnt_q != CW'(STALL_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Combinational outputs are forced low while reset is held so that no
    // input can leak through during reset.
    assign halt_o    = resetn_i ? halt_c  : '0;
    assign stall_o   = resetn_i ? stall_c : '0;
    assign pc_hold_o = resetn_i & stall_any;
    assign busy_o    = resetn_i & (pend_q | (|tok_q));
    assign timeout_o = resetn_i & timeout_c;

endmodule
